// File: rtl/ctrl_state_reg.sv
// ctrl_state_reg: registered half of the CPU control unit.
// Holds the control state, the instruction register and the N/P/Z/C flags.
// It also generates the fetch/flag-write strobes, a retire pulse with a
// wrapping retired-instruction counter, and a sticky illegal-state alarm.
module ctrl_state_reg #(
  parameter int          CNT_W       = 16,
  parameter logic [7:0]  FETCH_STATE = 8'h0F,
  parameter logic [7:0]  IDLE_STATE  = 8'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       next_state,
  input  logic             stall,
  input  logic [15:0]      mem_rdata,
  input  logic [3:0]       alu_flags,
  output logic [7:0]       state,
  output logic [15:0]      instr,
  output logic [3:0]       status_reg,
  output logic             ir_load,
  output logic             flag_we,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             illegal_state
);

  // Flag-writing states: sub2, add2, xor2, mul3, cpu1 (packed, 8 bits each).
  localparam int         NUM_FLAG_STATES = 5;
  localparam logic [39:0] FLAG_STATES    = {8'h27, 8'h12, 8'h0E, 8'h0B, 8'h08};

  logic [7:0]       state_reg;
  logic [15:0]      instr_reg;
  logic [3:0]       status_reg_q;
  logic             instr_done_reg;
  logic [CNT_W-1:0] retired_cnt_reg;
  logic             illegal_reg;

  logic [NUM_FLAG_STATES-1:0] flag_hit;
  logic                       state_legal;
  logic                       retire_edge;

  // One comparator per flag-writing state; flag_we is their OR.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLAG_STATES; gi++) begin : g_flag_decode
      assign flag_hit[gi] = (state_reg == FLAG_STATES[gi*8 +: 8]);
    end
  endgenerate

  assign flag_we = |flag_hit;
  assign ir_load = (state_reg == FETCH_STATE);

  // Legal map: 00..2F with a hole at 25, plus the lone 4A state.
  assign state_legal = ((state_reg <= 8'h2F) && (state_reg != 8'h25)) ||
                       (state_reg == 8'h4A);

  // An instruction retires when a legal non-idle state hands back to idle.
  assign retire_edge = !stall && (state_reg != IDLE_STATE) &&
                       (next_state == IDLE_STATE) && state_legal;

  // Control state: advances to the decoder's choice unless memory stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state_reg <= IDLE_STATE;
    else if (!stall) state_reg <= next_state;
  end

  // Instruction register: captures the fetched word on the fetch state exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 instr_reg <= 16'h0000;
    else if (ir_load && !stall) instr_reg <= mem_rdata;
  end

  // Status flags: written from the ALU in flag-writing states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 status_reg_q <= 4'h0;
    else if (flag_we && !stall) status_reg_q <= alu_flags;
  end

  // Retire pulse and counter; counter wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_done_reg  <= 1'b0;
      retired_cnt_reg <= '0;
    end else begin
      instr_done_reg <= retire_edge;
      if (retire_edge) retired_cnt_reg <= retired_cnt_reg + CNT_W'(1);
    end
  end

  // Sticky alarm: set whenever an illegal state is observed, stall or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            illegal_reg <= 1'b0;
    else if (!state_legal) illegal_reg <= 1'b1;
  end

  assign state         = state_reg;
  assign instr         = instr_reg;
  assign status_reg    = status_reg_q;
  assign instr_done    = instr_done_reg;
  assign retired_cnt   = retired_cnt_reg;
  assign illegal_state = illegal_reg;

endmodule

// File: tb/tb_ctrl_state_reg.sv
// Directed testbench for ctrl_state_reg (counter narrowed to 4 bits so the
// wrap case is reachable in a handful of retires).
module tb_ctrl_state_reg;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       next_state;
  logic             stall;
  logic [15:0]      mem_rdata;
  logic [3:0]       alu_flags;
  logic [7:0]       state;
  logic [15:0]      instr;
  logic [3:0]       status_reg;
  logic             ir_load;
  logic             flag_we;
  logic             instr_done;
  logic [CNT_W-1:0] retired_cnt;
  logic             illegal_state;

  int errors = 0;
  int checks = 0;

  ctrl_state_reg #(.CNT_W(CNT_W), .FETCH_STATE(8'h0F), .IDLE_STATE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .next_state(next_state), .stall(stall),
    .mem_rdata(mem_rdata), .alu_flags(alu_flags), .state(state), .instr(instr),
    .status_reg(status_reg), .ir_load(ir_load), .flag_we(flag_we),
    .instr_done(instr_done), .retired_cnt(retired_cnt), .illegal_state(illegal_state)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; next_state = 8'h00; mem_rdata = 16'h0; alu_flags = 4'h0;
    #12;
    checks++; if (state !== 8'h00) begin errors++; $display("FAIL reset_state got=%h exp=00", state); end
    checks++; if (instr !== 16'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0000", instr); end
    checks++; if (status_reg !== 4'h0) begin errors++; $display("FAIL reset_status got=%h exp=0", status_reg); end
    checks++; if (retired_cnt !== 4'h0 || instr_done !== 1'b0 || illegal_state !== 1'b0) begin
      errors++; $display("FAIL reset_misc got cnt=%h done=%b ill=%b exp 0/0/0", retired_cnt, instr_done, illegal_state); end
    rst_n = 1'b1;
    $display("test_reset complete");
  endtask

  task automatic test_fetch();
    next_state = 8'h0F; mem_rdata = 16'h1111; step();
    checks++; if (state !== 8'h0F || ir_load !== 1'b1 || flag_we !== 1'b0) begin
      errors++; $display("FAIL fetch_enter got state=%h ir_load=%b flag_we=%b exp 0F/1/0", state, ir_load, flag_we); end
    checks++; if (instr !== 16'h0) begin errors++; $display("FAIL fetch_early got=%h exp=0000", instr); end
    next_state = 8'h01; mem_rdata = 16'h2345; step();
    checks++; if (state !== 8'h01 || instr !== 16'h2345 || ir_load !== 1'b0) begin
      errors++; $display("FAIL fetch_latch got state=%h instr=%h ir_load=%b exp 01/2345/0", state, instr, ir_load); end
    $display("test_fetch complete");
  endtask

  task automatic test_add_retire();
    next_state = 8'h09; step();
    next_state = 8'h0A; step();
    checks++; if (flag_we !== 1'b0) begin errors++; $display("FAIL add_0A_flag_we got=%b exp=0", flag_we); end
    next_state = 8'h0B; step();
    alu_flags = 4'b0010;
    checks++; if (flag_we !== 1'b1 || status_reg !== 4'h0) begin
      errors++; $display("FAIL add_0B got flag_we=%b status=%h exp 1/0", flag_we, status_reg); end
    next_state = 8'h00; step();
    checks++; if (state !== 8'h00 || status_reg !== 4'b0010) begin
      errors++; $display("FAIL add_flags got state=%h status=%b exp 00/0010", state, status_reg); end
    checks++; if (instr_done !== 1'b1 || retired_cnt !== 4'd1) begin
      errors++; $display("FAIL add_retire got done=%b cnt=%0d exp 1/1", instr_done, retired_cnt); end
    step();
    checks++; if (instr_done !== 1'b0 || retired_cnt !== 4'd1) begin
      errors++; $display("FAIL add_pulse_end got done=%b cnt=%0d exp 0/1", instr_done, retired_cnt); end
    $display("test_add_retire complete");
  endtask

  task automatic test_stall();
    next_state = 8'h0F; step();
    stall = 1'b1; next_state = 8'h01;
    for (int i = 0; i < 3; i++) begin
      mem_rdata = 16'hA000 + 16'(i); step();
      checks++; if (state !== 8'h0F || instr !== 16'h2345 || retired_cnt !== 4'd1 || ir_load !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d got state=%h instr=%h cnt=%0d ir_load=%b exp 0F/2345/1/1",
                           i, state, instr, retired_cnt, ir_load); end
    end
    stall = 1'b0; mem_rdata = 16'h5A5A; step();
    checks++; if (state !== 8'h01 || instr !== 16'h5A5A) begin
      errors++; $display("FAIL stall_release got state=%h instr=%h exp 01/5A5A", state, instr); end
    next_state = 8'h00; stall = 1'b1; step();
    checks++; if (state !== 8'h01 || instr_done !== 1'b0 || retired_cnt !== 4'd1) begin
      errors++; $display("FAIL stall_retire_block got state=%h done=%b cnt=%0d exp 01/0/1", state, instr_done, retired_cnt); end
    stall = 1'b0; step();
    checks++; if (state !== 8'h00 || instr_done !== 1'b1 || retired_cnt !== 4'd2) begin
      errors++; $display("FAIL stall_retire got state=%h done=%b cnt=%0d exp 00/1/2", state, instr_done, retired_cnt); end
    $display("test_stall complete");
  endtask

  task automatic test_illegal();
    next_state = 8'h25; step();
    checks++; if (state !== 8'h25 || illegal_state !== 1'b0) begin
      errors++; $display("FAIL illegal_enter got state=%h ill=%b exp 25/0", state, illegal_state); end
    next_state = 8'h00; step();
    checks++; if (illegal_state !== 1'b1 || retired_cnt !== 4'd2 || instr_done !== 1'b0) begin
      errors++; $display("FAIL illegal_set got ill=%b cnt=%0d done=%b exp 1/2/0", illegal_state, retired_cnt, instr_done); end
    next_state = 8'h4A; step();
    next_state = 8'h00; step();
    checks++; if (illegal_state !== 1'b1 || retired_cnt !== 4'd3 || instr_done !== 1'b1) begin
      errors++; $display("FAIL illegal_sticky_4A got ill=%b cnt=%0d done=%b exp 1/3/1", illegal_state, retired_cnt, instr_done); end
    $display("test_illegal complete");
  endtask

  task automatic test_reset_mid();
    next_state = 8'h0B; step();
    alu_flags = 4'b1101;
    checks++; if (state !== 8'h0B || flag_we !== 1'b1) begin
      errors++; $display("FAIL rstmid_setup got state=%h flag_we=%b exp 0B/1", state, flag_we); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (state !== 8'h00 || instr !== 16'h0 || status_reg !== 4'h0) begin
      errors++; $display("FAIL rstmid_regs got state=%h instr=%h status=%h exp 00/0000/0", state, instr, status_reg); end
    checks++; if (instr_done !== 1'b0 || retired_cnt !== 4'd0 || illegal_state !== 1'b0) begin
      errors++; $display("FAIL rstmid_misc got done=%b cnt=%0d ill=%b exp 0/0/0", instr_done, retired_cnt, illegal_state); end
    next_state = 8'h00;
    #2 rst_n = 1'b1;
    step();
    checks++; if (retired_cnt !== 4'd0 || instr_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_retire got cnt=%0d done=%b exp 0/0", retired_cnt, instr_done); end
    $display("test_reset_mid complete");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 15; i++) begin
      next_state = 8'h01; step();
      next_state = 8'h00; step();
    end
    checks++; if (retired_cnt !== 4'hF) begin errors++; $display("FAIL wrap_preload got=%0d exp=15", retired_cnt); end
    next_state = 8'h01; step();
    next_state = 8'h00; step();
    checks++; if (retired_cnt !== 4'h0 || instr_done !== 1'b1) begin
      errors++; $display("FAIL wrap got cnt=%0d done=%b exp 0/1", retired_cnt, instr_done); end
    $display("test_wrap complete");
  endtask

  task automatic test_illegal_stall();
    next_state = 8'h30; step();
    checks++; if (state !== 8'h30 || illegal_state !== 1'b0) begin
      errors++; $display("FAIL ill_stall_enter got state=%h ill=%b exp 30/0", state, illegal_state); end
    stall = 1'b1; next_state = 8'h00; step();
    checks++; if (state !== 8'h30 || illegal_state !== 1'b1) begin
      errors++; $display("FAIL ill_stall_set got state=%h ill=%b exp 30/1", state, illegal_state); end
    stall = 1'b0; step();
    checks++; if (state !== 8'h00 || retired_cnt !== 4'h0 || instr_done !== 1'b0) begin
      errors++; $display("FAIL ill_stall_exit got state=%h cnt=%0d done=%b exp 00/0/0", state, retired_cnt, instr_done); end
    $display("test_illegal_stall complete");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_add_retire();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_wrap();
    test_illegal_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_state_reg.md
Name: ctrl_state_reg

Overview:
- Sequential half of the CPU control unit. Sits directly downstream of the combinational next-state decoder.
- Registers the control state and latches the fetched instruction word. Holds the N/P/Z/C status flags.
- Feeds state, instr and status_reg back to the decoder.
- Also produces fetch/flag-write strobes, an instruction-retire pulse and counter, and a sticky illegal-state alarm.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- FETCH_STATE, 8'h0F, state in which the instruction word is latched
- IDLE_STATE, 8'h00, reset/instruction-boundary state

Ports:
- clk  input  1  system clock, all registers on rising edge
- rst_n  input  1  asynchronous active-low reset
- next_state  input  8  state code from next-state decoder
- stall  input  1  1 = hold all registers this cycle (memory wait)
- mem_rdata  input  16  instruction word from program memory
- alu_flags  input  4  {N,P,Z,C} computed by ALU this cycle
- state  output  8  current control state (registered)
- instr  output  16  instruction register (registered)
- status_reg  output  4  {N,P,Z,C} flags (registered); bit3=N, bit2=P, bit1=Z, bit0=C
- ir_load  output  1  combinational, high while state==FETCH_STATE
- flag_we  output  1  combinational, high in flag-writing states
- instr_done  output  1  registered one-cycle retire pulse
- retired_cnt  output  CNT_W  retired-instruction count (registered)
- illegal_state  output  1  sticky alarm (registered)

Behaviour:
- Reset (rst_n=0, asynchronous, immediate):
  - state=IDLE_STATE, instr=16'h0000, status_reg=4'h0
  - instr_done=0, retired_cnt=0, illegal_state=0
  - Reset mid-instruction aborts it; no retire is counted.
- State register: on each edge with stall=0, state<=next_state. With stall=1, state holds.
- Instruction register:
  - ir_load = (state==FETCH_STATE), independent of stall.
  - instr<=mem_rdata on an edge where ir_load=1 and stall=0; otherwise holds.
  - Latency: instr valid the cycle state becomes 8'h01.
- Flags:
  - flag_we=1 when state is one of 8'h08 (sub2), 8'h0B (add2), 8'h0E (xor2), 8'h12 (mul3), 8'h27 (cpu1).
  - On an edge with flag_we=1 and stall=0, status_reg<=alu_flags; otherwise holds.
  - The new flags are visible to the decoder in the next state.
- Retire:
  - A retire edge is an edge where stall=0, state!=IDLE_STATE, next_state==IDLE_STATE and state is legal.
  - On a retire edge: instr_done<=1, retired_cnt<=retired_cnt+1, wrapping all-ones->0.
  - On every other edge: instr_done<=0 and the counter holds.
  - Reset-to-idle via an illegal state never counts.
- Legal states: 8'h00–8'h2F except 8'h25, plus 8'h4A.
- Illegal state:
  - On any edge (stall ignored) where state is not legal, illegal_state<=1.
  - Cleared only by rst_n.
  - The state register still loads next_state (the decoder defaults to idle).
- Stall precedence: stall=1 freezes state, instr, status_reg and retired_cnt; instr_done is 0 that cycle.
- Simultaneous events:
  - The flag write and the retire may occur on the same edge; both take effect.
  - ir_load and flag_we are never high together (disjoint states).

Test Plan:
1. Reset: assert rst_n=0 mid-cycle with state=8'h0B -> all outputs go to 0 immediately, without waiting for a clock edge.
2. Fetch: drive next_state sequence 00->0F->01 with mem_rdata=16'h2345 during state 0F -> instr=16'h2345 when state=01; ir_load high for exactly one cycle.
3. ADD flags plus retire: walk 01->09->0A->0B->00 with alu_flags=4'b0010 in state 0B. Required response:
   - status_reg=4'b0010 in the cycle state=00
   - instr_done high for that one cycle
   - retired_cnt=1
4. Stall: hold stall=1 for 3 cycles while state=0F and mem_rdata changes -> state, instr and counter unchanged; the latch occurs on the first edge with stall=0.
5. Illegal state: force next_state=8'h25, then 8'h00 -> illegal_state=1 and stays 1, retired_cnt unchanged; cleared only by rst_n.
6. Counter wrap: preload via 2^CNT_W-1 retires (or CNT_W=4 with 15 retires), then retire once -> retired_cnt=0 and instr_done pulses.
